// File: rtl/change_dispenser.sv
// change_dispenser: pays out credit - price as a greedy sequence of 20/10/5
// coins to a hopper over a coin_valid/coin_ack handshake. It reports done,
// an error code and the unpaid remainder back to the vend FSM.
//
// Handshake: coin_valid rises with a stable coin_out code and both are held
// until the first rising edge where coin_ack=1; that edge completes the coin.
// coin_ack is ignored whenever coin_valid is low. If no ack arrives within
// ACK_TIMEOUT cycles, the request is withdrawn and the payout ends with err=10.
`timescale 1ns/1ps
module change_dispenser #(
  parameter int WIDTH       = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] credit,
  input  logic [WIDTH-1:0] price,
  output logic [1:0]       coin_out,
  output logic             coin_valid,
  input  logic             coin_ack,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err,
  output logic [WIDTH-1:0] remaining
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_ISSUE  = 3'd2,
    S_GAP    = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam int GW = (GAP_CYCLES  > 1) ? $clog2(GAP_CYCLES  + 1) : 1;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  localparam logic [WIDTH-1:0] C5  = WIDTH'(5);
  localparam logic [WIDTH-1:0] C10 = WIDTH'(10);
  localparam logic [WIDTH-1:0] C20 = WIDTH'(20);

  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(ACK_TIMEOUT - 1);

  // Hopper coin codes, shared with the coin acceptor.
  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_5    = 2'b01;
  localparam logic [1:0] CODE_10   = 2'b10;
  localparam logic [1:0] CODE_20   = 2'b11;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_PRICE   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_UNPAY   = 2'b11;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic [1:0]       coin_out_q, coin_out_d;
  logic             coin_valid_q, coin_valid_d;
  logic [1:0]       err_q, err_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [TW-1:0]    to_cnt_q, to_cnt_d;

  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] coin_val;

  // Extra top bit of the subtraction is the borrow (price > credit).
  assign diff = {1'b0, credit} - {1'b0, price};

  // Value of the coin currently being requested, used on its ack.
  always_comb begin
    coin_val = '0;
    case (coin_out_q)
      CODE_20: coin_val = C20;
      CODE_10: coin_val = C10;
      CODE_5:  coin_val = C5;
      default: coin_val = '0;
    endcase
  end

  // Next-state and register-update decisions for the payout sequence.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    coin_out_d   = coin_out_q;
    coin_valid_d = coin_valid_q;
    err_d        = err_q;
    gap_cnt_d    = gap_cnt_q;
    to_cnt_d     = to_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (diff[WIDTH]) begin
            remaining_d = credit;
            err_d       = ERR_PRICE;
            state_d     = S_FINISH;
          end else begin
            remaining_d = diff[WIDTH-1:0];
            err_d       = ERR_OK;
            state_d     = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        if (remaining_q >= C5) begin
          if (remaining_q >= C20)      coin_out_d = CODE_20;
          else if (remaining_q >= C10) coin_out_d = CODE_10;
          else                         coin_out_d = CODE_5;
          coin_valid_d = 1'b1;
          to_cnt_d     = '0;
          state_d      = S_ISSUE;
        end else if (remaining_q == '0) begin
          state_d = S_FINISH;
        end else begin
          err_d   = ERR_UNPAY;
          state_d = S_FINISH;
        end
      end

      S_ISSUE: begin
        // An ack on the final allowed cycle still completes the coin.
        if (coin_ack) begin
          remaining_d  = remaining_q - coin_val;
          coin_valid_d = 1'b0;
          coin_out_d   = CODE_NONE;
          gap_cnt_d    = '0;
          state_d      = S_GAP;
        end else if (to_cnt_q == TO_LAST) begin
          coin_valid_d = 1'b0;
          coin_out_d   = CODE_NONE;
          err_d        = ERR_TIMEOUT;
          state_d      = S_FINISH;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_CHECK;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d      = S_IDLE;
        coin_valid_d = 1'b0;
        coin_out_d   = CODE_NONE;
      end
    endcase
  end

  // State and datapath registers; reset drops any pending coin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      remaining_q  <= '0;
      coin_out_q   <= CODE_NONE;
      coin_valid_q <= 1'b0;
      err_q        <= ERR_OK;
      gap_cnt_q    <= '0;
      to_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      coin_out_q   <= coin_out_d;
      coin_valid_q <= coin_valid_d;
      err_q        <= err_d;
      gap_cnt_q    <= gap_cnt_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  assign coin_out   = coin_out_q;
  assign coin_valid = coin_valid_q;
  assign err        = err_q;
  assign remaining  = remaining_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FINISH);

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: a reference model pushes the expected coin
// sequence and final status per payout; a monitor compares as the DUT
// presents coins and done pulses.
`timescale 1ns/1ps
module tb_change_dispenser;

  localparam int WIDTH = 8;
  localparam int GAP   = 2;
  localparam int TO    = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] credit;
  logic [WIDTH-1:0] price;
  logic [1:0]       coin_out;
  logic             coin_valid;
  logic             coin_ack;
  logic             busy;
  logic             done;
  logic [1:0]       err;
  logic [WIDTH-1:0] remaining;

  // Clock / reset
  always #5 clk = ~clk;

  change_dispenser #(
    .WIDTH      (WIDTH),
    .GAP_CYCLES (GAP),
    .ACK_TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .credit    (credit),
    .price     (price),
    .coin_out  (coin_out),
    .coin_valid(coin_valid),
    .coin_ack  (coin_ack),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .remaining (remaining)
  );

  int errors = 0;
  int checks = 0;

  logic [1:0]       exp_coin_q[$];
  logic [1:0]       exp_err_q[$];
  logic [WIDTH-1:0] exp_rem_q[$];
  int               exp_lat_q[$];
  int               ack_dly_q[$];
  bit               ack_noise = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference model: greedy change from plain arithmetic. Each coin gets an
  // ack delay d (ack in ISSUE cycle d+1); d >= TO means the hopper never acks.
  // Latency counts edges from the start edge until done is visible.
  task automatic issue_payout(input int cr, input int pr, input int dmode);
    int rem, val, d, lat;
    logic [1:0] e;
    bit timed;
    timed = 1'b0;
    lat   = 0;
    if (cr < pr) begin
      e   = 2'b01;
      rem = cr;
    end else begin
      e   = 2'b00;
      rem = cr - pr;
      while (rem >= 5) begin
        val = (rem >= 20) ? 20 : (rem >= 10) ? 10 : 5;
        if (dmode < 0)
          d = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 2) : $urandom_range(0, 3);
        else
          d = dmode;
        exp_coin_q.push_back((val == 20) ? 2'b11 : (val == 10) ? 2'b10 : 2'b01);
        ack_dly_q.push_back(d);
        if (d >= TO) begin
          e     = 2'b10;
          lat  += 1 + TO;
          timed = 1'b1;
          break;
        end
        rem -= val;
        lat += 1 + (d + 1) + GAP;
      end
      if (!timed) begin
        lat += 1;
        if (rem != 0) e = 2'b11;
      end
    end
    exp_err_q.push_back(e);
    exp_rem_q.push_back(rem[WIDTH-1:0]);
    exp_lat_q.push_back(lat);
    @(negedge clk);
    start  = 1'b1;
    credit = cr[WIDTH-1:0];
    price  = pr[WIDTH-1:0];
    @(negedge clk);
    start  = 1'b0;
    credit = WIDTH'($urandom);
    price  = WIDTH'($urandom);
  endtask

  // Wait for the payout to end, throwing ignored start pulses at the busy DUT.
  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (!busy) begin
        start = 1'b0;
        ok    = 1'b1;
        break;
      end
      start  = ($urandom_range(0, 3) == 0);
      credit = WIDTH'($urandom);
      price  = WIDTH'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    if (!ok) flag("payout_hang");
  endtask

  task automatic payout(input int cr, input int pr, input int dmode);
    issue_payout(cr, pr, dmode);
    wait_idle();
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // Hopper driver: acks each coin window after its scheduled delay.
  initial begin : ack_driver
    bit in_win;
    int wc, d;
    in_win   = 1'b0;
    wc       = 0;
    d        = 0;
    coin_ack = 1'b0;
    forever begin
      @(negedge clk);
      coin_ack = 1'b0;
      if (rst || !coin_valid) begin
        in_win = 1'b0;
        if (ack_noise && !rst) coin_ack = ($urandom_range(0, 3) == 0);
      end else begin
        if (!in_win) begin
          in_win = 1'b1;
          wc     = 0;
          d      = 0;
          if (ack_dly_q.size() > 0) d = ack_dly_q.pop_front();
        end
        if (wc == d) coin_ack = 1'b1;
        wc++;
      end
    end
  end

  // Monitor / scoreboard: samples 1 ns after each rising edge.
  initial begin : monitor
    logic       pv, pb;
    logic [1:0] held;
    int         low_cnt, win_len, mcyc, start_cyc;
    bit         seen_coin;
    pv = 1'b0; pb = 1'b0; held = 2'b00;
    low_cnt = 0; win_len = 0; mcyc = 0; start_cyc = 0; seen_coin = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      mcyc++;
      if (rst) begin
        pv = 1'b0; pb = 1'b0; win_len = 0; seen_coin = 1'b0;
        continue;
      end
      if (busy && !pb) begin
        start_cyc = mcyc;
        seen_coin = 1'b0;
        low_cnt   = 0;
      end
      if (coin_valid) begin
        if (!pv) begin
          if (seen_coin) check("coin_gap_ok", (low_cnt >= GAP), 1);
          if (exp_coin_q.size() == 0) flag("unexpected_coin");
          else check("coin_code", coin_out, exp_coin_q.pop_front());
          held      = coin_out;
          win_len   = 0;
          seen_coin = 1'b1;
        end else begin
          check("coin_stable", coin_out, held);
        end
        win_len++;
      end else begin
        if (coin_out !== 2'b00) check("coin_out_idle", coin_out, 0);
        if (pv && !coin_ack) check("timeout_len", win_len, TO);
        if (pv) low_cnt = 0;
        low_cnt++;
      end
      if (done) begin
        check("busy_in_finish", busy, 1);
        if (exp_err_q.size() == 0) begin
          flag("unexpected_done");
        end else begin
          check("err", err, exp_err_q.pop_front());
          check("remaining", remaining, exp_rem_q.pop_front());
          check("latency", mcyc - start_cyc, exp_lat_q.pop_front());
        end
      end
      pv = coin_valid;
      pb = busy;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_coin_valid"}, coin_valid, 0);
    check({tag, "_coin_out"},   coin_out,   0);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_done"},       done,       0);
    check({tag, "_err"},        err,        0);
    check({tag, "_remaining"},  remaining,  0);
  endtask

  // Reset in the middle of a coin request: everything clears, no done.
  task automatic reset_mid_issue();
    bit seen;
    seen = 1'b0;
    issue_payout(60, 0, TO + 2);
    for (int n = 0; n < 20; n++) begin
      if (coin_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) flag("rst_no_coin_valid");
    @(negedge clk);
    #2;
    rst   = 1'b1;
    start = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    exp_coin_q.delete();
    exp_err_q.delete();
    exp_rem_q.delete();
    exp_lat_q.delete();
    ack_dly_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_after");
  endtask

  // Main stimulus
  initial begin
    int cr, pr;
    rst    = 1'b1;
    start  = 1'b0;
    credit = '0;
    price  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    payout(35, 15, 0);       // one 20 coin, latency 5
    payout(40, 5, 0);        // 20, 10, 5
    payout(10, 15, 0);       // price error
    payout(17, 10, 0);       // 5 then unpayable 2
    payout(35, 15, TO);      // no ack: timeout
    payout(35, 15, TO - 1);  // ack on last allowed cycle wins
    payout(20, 20, 0);       // zero change
    payout(14, 10, 0);       // remainder 4, no coin
    payout(255, 0, 1);       // long payout with ack delays
    payout(0, 255, 0);       // maximal borrow

    ack_noise = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cr = $urandom_range(0, 255);
      if ($urandom_range(0, 5) == 0) pr = $urandom_range(0, 255);
      else                           pr = $urandom_range(0, cr);
      payout(cr, pr, -1);
    end

    reset_mid_issue();
    payout(45, 10, 0);       // normal payout after reset

    repeat (5) @(negedge clk);
    check("coin_q_drained", exp_coin_q.size(), 0);
    check("result_q_drained", exp_err_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Payout engine that returns change after a vend. On a `start` pulse it computes `credit - price` and ejects that amount as a greedy sequence of 20/10/5 coins to a coin hopper over a valid/ack handshake. Coin codes match the coin-acceptor encoding on `ui_in[1:0]`: 01=5, 10=10, 11=20. The block sits between the vend FSM (which supplies balance and price) and the hopper driver, and reports completion and error status back to the FSM.

## Interface
- `WIDTH`, 8: width of `credit`, `price`, `remaining`.
- `GAP_CYCLES`, 2: idle cycles (`coin_valid` low) between consecutive coins; ≥1.
- `ACK_TIMEOUT`, 16: maximum cycles `coin_valid` waits for `coin_ack`; ≥1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin payout; sampled only in IDLE.
- `credit`  in  WIDTH  inserted balance; sampled with `start`.
- `price`  in  WIDTH  item price; sampled with `start`.
- `coin_out`  out  2  coin code to hopper; 00 when `coin_valid`=0.
- `coin_valid`  out  1  coin request to hopper.
- `coin_ack`  in  1  hopper has ejected the requested coin.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at payout end.
- `err`  out  2  00 ok, 01 price>credit, 10 ack timeout, 11 unpayable remainder; held until next accepted `start`.
- `remaining`  out  WIDTH  change not yet paid.

## Operation
- States: IDLE, CHECK, ISSUE, GAP, FINISH. All outputs are registered or decoded from state.
- Reset values: state IDLE, `coin_out`=00, `coin_valid`=0, `busy`=0, `done`=0, `err`=00, `remaining`=0, and all counters 0.
- IDLE with `start`=1:
  - Compute `credit - price` in WIDTH+1 bits.
  - No borrow: `remaining` ← difference, `err` ← 00, go to CHECK.
  - Borrow: `remaining` ← `credit`, `err` ← 01, go to FINISH (no coins issued).
- CHECK:
  - `remaining` ≥ 5: go to ISSUE. `coin_out` ← 11 if `remaining` ≥20, else 10 if ≥10, else 01. `coin_valid` ← 1. Timeout counter ← 0.
  - `remaining` = 0: go to FINISH, `err` stays 00.
  - `remaining` in 1..4: go to FINISH, `err` ← 11, `remaining` held.
- ISSUE:
  - `coin_valid` and `coin_out` stay stable until an edge where `coin_ack`=1.
  - On that edge: `remaining` −= coin value (5/10/20), `coin_valid` ← 0, `coin_out` ← 00, go to GAP with gap counter ← 0.
  - Timeout: on the edge ending the ACK_TIMEOUT-th ISSUE cycle with `coin_ack`=0, `coin_valid` ← 0, `err` ← 10, go to FINISH. `remaining` is not decremented.
  - Ack and timeout on the same edge: ack wins.
- GAP: hold for GAP_CYCLES cycles, then go to CHECK. `coin_ack` is ignored outside ISSUE.
- FINISH: `done`=1 for exactly this cycle, then go to IDLE.
- `start` is ignored in any state other than IDLE. `credit` and `price` are don't-care outside the start edge.
- `rst` asserted in any state: immediate return to reset values. A pending coin is dropped; no `done` pulse.
- Coin values are zero-extended to WIDTH. `remaining` never underflows, since a coin is only chosen when it is ≤ `remaining`.

## Timing
- Start accepted at edge E0: `busy`=1 after E0.
- CHECK decision occurs at E1; `coin_valid`=1 after E1 at the earliest.
- Each coin with ack in its first ISSUE cycle costs 1 (ISSUE) + GAP_CYCLES + 1 (CHECK) cycles.
- Zero change: `done` high in the cycle after E1; `busy` low after E2.
- Price error: `done` high in the cycle after E0.
- `err` and `remaining` are valid when `done`=1 and stay stable in IDLE.
- `coin_valid` is never high in two consecutive coin windows without at least GAP_CYCLES low cycles between them.

## Test plan
- `credit`=35, `price`=15: one coin 11; ack on first ISSUE cycle → `remaining` 20→0; `done` pulse, `err`=00. Total latency from E0 to `done` = 5 cycles with GAP_CYCLES=2.
- `credit`=40, `price`=5: coins issued in order 11, 10, 01; `remaining` 35→15→5→0; ≥2 low cycles of `coin_valid` between coins; `err`=00.
- `credit`=10, `price`=15: `coin_valid` never rises; `done` in the cycle after E0; `err`=01, `remaining`=10.
- `credit`=17, `price`=10: coin 01 acked, `remaining` 7→2; then `done` with `err`=11, `remaining`=2.
- ACK_TIMEOUT=8, change 20, `coin_ack` held 0: `coin_valid` high exactly 8 cycles, then `done` with `err`=10, `remaining`=20. Repeat with ack on the 8th cycle: ack wins, `err`=00.
- `rst` pulsed mid-ISSUE with `coin_valid`=1: all outputs reset immediately; no `done`; `start` during busy ignored; new `start` after reset behaves normally.
